aes128_encrypt_pipe: RTL and testbench

//   Fully unrolled, fully pipelined AES-128 encryptor (FIPS-197) with one block per clock throughput.

---
 rtl/aes128_encrypt_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_aes128_encrypt_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt_pipe.sv
// -----------------------------------------------------------------------------
// aes128_encrypt_pipe
//
// Fully unrolled AES-128 encryptor that accepts one block per clock. Every
// block travels down the pipeline with its own cipher key, and each stage
// performs one key-schedule step next to its round. The key may therefore
// change on every block. There is no back-pressure: valid bits shift forward
// every cycle.
//
// Pipeline: stage 0 (initial AddRoundKey), stages 1..9 (full rounds),
// stage 10 (final round, no MixColumns), then the output register. A block
// accepted at posedge k appears on data_out with done=1 after posedge k+11.
//
// Ports
//   clk       in   1    clock, rising edge
//   reset     in   1    synchronous, active-low reset
//   start     in   1    input valid; data_in/key_in captured when high
//   data_in   in   128  plaintext, bit 127 = byte 0 (column-major state)
//   key_in    in   128  cipher key for this block, same byte order
//   data_out  out  128  ciphertext, valid while done=1
//   done      out  1    one-cycle valid pulse per accepted block
//
// Build option
//   AES_OUT_ZERO_EN  defined  : data_out is 0 in every cycle where done=0.
//                    undefined: data_out holds the last ciphertext produced
//                               and is cleared only by reset.
// -----------------------------------------------------------------------------
module aes128_encrypt_pipe (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] data_out,
    output logic         done
);

    // GF(2^8) multiply by x, reduction polynomial 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // S-box computed as multiplicative inverse (x^254, which maps 0 to 0)
    // followed by the affine transform, so no 256-entry table is needed.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);   // x^(2^i)
            inv = gf_mul(inv, sq);  // accumulate x^(2+4+...+128) = x^254
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Byte n sits at bits [127-8n -: 8]; byte n is row n%4, column n/4.
    // Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // One key-schedule step: previous round key -> next round key
    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        // SubWord(RotWord(w3)) ^ Rcon
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] rcon_of(input int r);
        case (r)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            default: return 8'h36;
        endcase
    endfunction

    // Pipeline registers. r_key[10] is never needed: the last round key is
    // consumed combinationally inside stage 10.
    logic [127:0] r_state [0:10];
    logic [127:0] r_key   [0:9];
    logic [10:0]  r_valid;
    logic [127:0] r_data_out;
    logic         r_done;

    logic [127:0] w_state_next [1:10];
    logic [127:0] w_key_next   [1:10];

    genvar gi;
    generate
        for (gi = 1; gi <= 10; gi++) begin : g_round
            logic [127:0] w_shifted;
            assign w_key_next[gi] = key_step(r_key[gi-1], rcon_of(gi));
            assign w_shifted      = shift_rows(sub_bytes(r_state[gi-1]));
            if (gi < 10) begin : g_mix
                assign w_state_next[gi] = mix_columns(w_shifted) ^ w_key_next[gi];
            end else begin : g_last
                assign w_state_next[gi] = w_shifted ^ w_key_next[gi];
            end
        end
    endgenerate

    // Datapath registers load every cycle; only the valid bits carry meaning
    always_ff @(posedge clk) begin
        r_state[0] <= data_in ^ key_in;
        r_key[0]   <= key_in;
        for (int i = 1; i <= 10; i++) begin
            r_state[i] <= w_state_next[i];
        end
        for (int i = 1; i <= 9; i++) begin
            r_key[i] <= w_key_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= {r_valid[9:0], start};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_done     <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_done <= r_valid[10];
`ifdef AES_OUT_ZERO_EN
            r_data_out <= r_valid[10] ? r_state[10] : 128'h0;
`else
            if (r_valid[10]) begin
                r_data_out <= r_state[10];
            end
`endif
        end
    end

    assign data_out = r_data_out;
    assign done     = r_done;

endmodule

// File: tb/tb_aes128_encrypt_pipe.sv
module tb_aes128_encrypt_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [127:0] data_out;
    logic         done;

    always #5 clk = ~clk;

    aes128_encrypt_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .key_in   (key_in),
        .data_out (data_out),
        .done     (done)
    );

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h000102030405063923090a0b0c0d0e0f;
    localparam logic [127:0] P2A = 128'h0011223344556677ff99aabbfcddeeff;
    localparam logic [127:0] P2B = 128'h0011223344556636ff99aabbfcddeeff;

    int total = 0;
    int bad   = 0;
    logic [127:0] last_ct;

    // ---------------- reference model (byte arrays + log/antilog tables) ----
    logic [7:0] exp_t [256];
    int         log_t [256];
    logic [7:0] sbox_t [256];

    task automatic build_tables();
        logic [7:0] x;
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x ^ {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00); // times generator 3
        end
        exp_t[255] = exp_t[0];
        log_t[0]   = 0;
        for (int v = 0; v < 256; v++) begin
            inv = (v == 0) ? 8'h00 : exp_t[(255 - log_t[v]) % 255];
            for (int b = 0; b < 8; b++) begin
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            end
            sbox_t[v] = s;
        end
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   st  [16];
        logic [7:0]   tmp [16];
        logic [7:0]   w   [44][4];
        logic [7:0]   t   [4];
        logic [7:0]   a   [4];
        logic [7:0]   t0;
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            st[i]         = pt[127 - 8*i -: 8];
            w[i/4][i%4]   = key[127 - 8*i -: 8];
        end
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 4 == 0) begin
                t0   = t[0];
                t[0] = sbox_t[t[1]] ^ rc;
                t[1] = sbox_t[t[2]];
                t[2] = sbox_t[t[3]];
                t[3] = sbox_t[t0];
                rc   = mul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
        end
        for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[i/4][i%4];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sbox_t[st[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    tmp[4*c + row] = st[4*((c + row) % 4) + row];
            for (int i = 0; i < 16; i++) st[i] = tmp[i];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int row = 0; row < 4; row++) a[row] = st[4*c + row];
                    for (int row = 0; row < 4; row++)
                        st[4*c + row] = mul(8'h02, a[row]) ^ mul(8'h03, a[(row+1)%4])
                                      ^ a[(row+2)%4] ^ a[(row+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][i%4];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
        return res;
    endfunction

    // Expected data_out in a cycle where done=0
    function automatic logic [127:0] idle_val();
`ifdef AES_OUT_ZERO_EN
        return 128'h0;
`else
        return last_ct;
`endif
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Apply inputs for the next posedge, then wait until just after it
    task automatic step(input logic rs, input logic s, input logic [127:0] d, input logic [127:0] k);
        reset   = rs;
        start   = s;
        data_in = d;
        key_in  = k;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ---------------------------------------------------
    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b1, rnd128(), rnd128());
            total++;
            if (done !== 1'b0) begin bad++; $display("FAIL reset_done cyc=%0d got=%b exp=0", c, done); end
            total++;
            if (data_out !== 128'h0) begin bad++; $display("FAIL reset_data cyc=%0d got=%h exp=0", c, data_out); end
        end
        last_ct = 128'h0;
        for (int c = 0; c < 14; c++) begin
            step(1'b1, 1'b0, rnd128(), rnd128());
            total++;
            if (done !== 1'b0) begin bad++; $display("FAIL reset_nodone cyc=%0d got=%b exp=0", c, done); end
            total++;
            if (data_out !== 128'h0) begin bad++; $display("FAIL reset_nodata cyc=%0d got=%h exp=0", c, data_out); end
        end
    endtask

    task automatic test_fips_c1();
        logic exp_d;
        for (int c = 0; c < 14; c++) begin
            step(1'b1, c == 0, P1, K1);
            exp_d = (c == 11);
            total++;
            if (done !== exp_d) begin bad++; $display("FAIL c1_done cyc=%0d got=%b exp=%b", c, done, exp_d); end
            total++;
            if (exp_d) begin
                if (data_out !== C1) begin bad++; $display("FAIL c1_data got=%h exp=%h", data_out, C1); end
                last_ct = C1;
            end else if (data_out !== idle_val()) begin
                bad++; $display("FAIL c1_idle cyc=%0d got=%h exp=%h", c, data_out, idle_val());
            end
        end
    endtask

    task automatic test_streaming();
        logic [127:0] q[$];
        logic         hist [0:63];
        logic         exp_d;
        logic [127:0] d;
        logic [127:0] ct;
        int           ndone = 0;
        for (int c = 0; c < 22; c++) begin
            d = (c % 2 == 0) ? P2A : P2B;
            hist[c] = (c < 10);
            if (hist[c]) q.push_back(aes_ref(d, K2));
            step(1'b1, hist[c], d, K2);
            exp_d = (c >= 11) ? hist[c-11] : 1'b0;
            if (done === 1'b1) ndone++;
            total++;
            if (done !== exp_d) begin bad++; $display("FAIL stream_done cyc=%0d got=%b exp=%b", c, done, exp_d); end
            total++;
            if (exp_d) begin
                ct = q.pop_front();
                if (data_out !== ct) begin bad++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", c, data_out, ct); end
                last_ct = ct;
            end else if (data_out !== idle_val()) begin
                bad++; $display("FAIL stream_idle cyc=%0d got=%h exp=%h", c, data_out, idle_val());
            end
        end
        total++;
        if (ndone != 10) begin bad++; $display("FAIL stream_count got=%0d exp=10", ndone); end
    endtask

    task automatic test_per_block_keys();
        logic [127:0] q[$];
        logic         exp_d;
        logic [127:0] d;
        logic [127:0] k;
        logic [127:0] ct;
        for (int c = 0; c < 20; c++) begin
            k = (c % 2 == 0) ? K1 : K2;
            d = (c % 4 < 2) ? P1 : rnd128();
            if (c < 8) q.push_back(aes_ref(d, k));
            step(1'b1, c < 8, d, k);
            exp_d = (c >= 11) && (c < 19);
            total++;
            if (done !== exp_d) begin bad++; $display("FAIL keys_done cyc=%0d got=%b exp=%b", c, done, exp_d); end
            total++;
            if (exp_d) begin
                ct = q.pop_front();
                if (data_out !== ct) begin bad++; $display("FAIL keys_data cyc=%0d got=%h exp=%h", c, data_out, ct); end
                last_ct = ct;
            end else if (data_out !== idle_val()) begin
                bad++; $display("FAIL keys_idle cyc=%0d got=%h exp=%h", c, data_out, idle_val());
            end
        end
    endtask

    task automatic test_bubbles();
        logic [127:0] q[$];
        logic         pat  [0:4];
        logic         hist [0:63];
        logic         exp_d;
        logic [127:0] d;
        logic [127:0] k;
        logic [127:0] ct;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 17; c++) begin
            d = rnd128();
            k = rnd128();
            hist[c] = (c < 5) ? pat[c] : 1'b0;
            if (hist[c]) q.push_back(aes_ref(d, k));
            step(1'b1, hist[c], d, k);
            exp_d = (c >= 11) ? hist[c-11] : 1'b0;
            total++;
            if (done !== exp_d) begin bad++; $display("FAIL bubble_done cyc=%0d got=%b exp=%b", c, done, exp_d); end
            total++;
            if (exp_d) begin
                ct = q.pop_front();
                if (data_out !== ct) begin bad++; $display("FAIL bubble_data cyc=%0d got=%h exp=%h", c, data_out, ct); end
                last_ct = ct;
            end else if (data_out !== idle_val()) begin
                bad++; $display("FAIL bubble_idle cyc=%0d got=%h exp=%h", c, data_out, idle_val());
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic         exp_d;
        logic [127:0] d;
        logic [127:0] k;
        logic [127:0] ct;
        ct = 128'h0;
        for (int c = 0; c < 20; c++) begin
            d = rnd128();
            k = rnd128();
            if (c == 6) ct = aes_ref(d, k);
            // blocks at cycles 0..4 are in flight when reset hits at cycle 5
            step(c != 5, c <= 6, d, k);
            if (c == 5) last_ct = 128'h0;
            exp_d = (c == 17);
            total++;
            if (done !== exp_d) begin bad++; $display("FAIL midrst_done cyc=%0d got=%b exp=%b", c, done, exp_d); end
            total++;
            if (exp_d) begin
                if (data_out !== ct) begin bad++; $display("FAIL midrst_data got=%h exp=%h", data_out, ct); end
                last_ct = ct;
            end else if (c == 5) begin
                if (data_out !== 128'h0) begin bad++; $display("FAIL midrst_clear got=%h exp=0", data_out); end
            end else if (data_out !== idle_val()) begin
                bad++; $display("FAIL midrst_idle cyc=%0d got=%h exp=%h", c, data_out, idle_val());
            end
        end
    endtask

    task automatic test_random_traffic();
        logic [127:0] q[$];
        logic         hist [0:63];
        logic         exp_d;
        logic [127:0] d;
        logic [127:0] k;
        logic [127:0] ct;
        for (int c = 0; c < 52; c++) begin
            d = rnd128();
            k = rnd128();
            hist[c] = (c < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (hist[c]) q.push_back(aes_ref(d, k));
            step(1'b1, hist[c], d, k);
            exp_d = (c >= 11) ? hist[c-11] : 1'b0;
            total++;
            if (done !== exp_d) begin bad++; $display("FAIL rand_done cyc=%0d got=%b exp=%b", c, done, exp_d); end
            total++;
            if (exp_d) begin
                ct = q.pop_front();
                if (data_out !== ct) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, data_out, ct); end
                last_ct = ct;
            end else if (data_out !== idle_val()) begin
                bad++; $display("FAIL rand_idle cyc=%0d got=%h exp=%h", c, data_out, idle_val());
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        key_in  = '0;
        last_ct = '0;
        build_tables();
        test_reset();
        test_fips_c1();
        test_streaming();
        test_per_block_keys();
        test_bubbles();
        test_reset_midstream();
        test_random_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
